riscv_mem_arbiter: RTL and testbench
====================================

// Module: riscv_mem_arbiter
// PURPOSE
//  Shares the single RV32I unified memory array between instruction fetch (I) and load/store (D).
//  It arbitrates between the two ports with fixed D priority plus a starvation guard.
//  It translates byte addresses to word indices (addr - ENTRY) >> 2 and range/alignment-checks them.
//  It tracks the one outstanding response and routes it back to its owner.
//  Sits between the core's fetch/LSU stages and the mem[] array.
// PARAMETERS
//  ENTRY         32'h8000_0000  byte address of mem word 0
//  MEMSIZE       2056           words in mem array
//  IDX_W         12             width of word index (2**IDX_W >= MEMSIZE)
//  D_STREAK_MAX  4              max consecutive D grants while I waits; must be >= 1
//  CNT_W         32             perf counter width
// PORTS
//  clk          in   1      single clock, all state updates on posedge
//  reset        in   1      synchronous, active-high
//  i_req        in   1      fetch request; i_addr held stable until i_gnt
//  i_addr       in   32     fetch byte address
//  i_gnt        out  1      fetch request accepted this cycle (combinational)
//  i_rvalid     out  1      fetch response valid (registered)
//  i_rdata      out  32     fetch instruction word
//  i_err        out  1      fetch fault (range/misaligned), qualified by i_rvalid
//  d_req        in   1      load/store request; d_* held stable until d_gnt
//  d_we         in   1      1=store, 0=load
//  d_wstrb      in   4      store byte lane enables
//  d_addr       in   32     data byte address
//  d_wdata      in   32     store data
//  d_gnt        out  1      data request accepted this cycle (combinational)
//  d_rvalid     out  1      data response valid; asserted for loads and stores
//  d_rdata      out  32     load data; 0 for stores and faults
//  d_err        out  1      data fault, qualified by d_rvalid
//  m_en         out  1      memory access enable
//  m_we         out  1      memory write enable
//  m_wstrb      out  4      memory byte lanes
//  m_idx        out  IDX_W  memory word index
//  m_wdata      out  32     memory write data
//  m_rdata      in   32     memory read data, valid 1 cycle after m_en
//  perf_i_cnt   out  CNT_W  I grants since reset
//  perf_d_cnt   out  CNT_W  D grants since reset
//  perf_stall   out  CNT_W  cycles with a request pending but not granted
// BEHAVIOUR
//  - Reset: all outputs 0. Response owner = NONE. Streak counter 0. Perf counters 0.
//  - One grant max per cycle. Requests are always grantable: the outstanding response retires the
//    next cycle, so a new grant can overlap a response (throughput 1/cycle).
//  - Arbitration:
//    - D wins if d_req, unless i_req && streak == D_STREAK_MAX; then I wins.
//    - I wins if only i_req.
//  - Streak counter:
//    - +1 on each D grant while i_req=1, saturating at D_STREAK_MAX.
//    - Cleared on any I grant, or in any cycle with i_req=0.
//    - Update happens in the grant cycle.
//  - Address check for the granted port:
//    - Fault if addr < ENTRY, or (addr - ENTRY) >> 2 >= MEMSIZE, or addr[1:0] != 0.
//    - Faulting grant: gnt=1, m_en=0. Response the next cycle with err=1, rdata=0.
//  - Good grant, cycle N:
//    - m_en=1; m_idx = (addr - ENTRY) >> 2 truncated to IDX_W.
//    - m_we and m_wstrb = d_we/d_wstrb for D; 0 for I. m_wdata = d_wdata, or 0.
//  - Response, cycle N+1: owner's rvalid=1, rdata=m_rdata (load/fetch), err=0. Other port's rvalid=0.
//  - Owner register holds NONE/I/D plus fault flag. It is loaded every cycle from the grant
//    decision, so no response is ever duplicated.
//  - Store with d_wstrb=0: m_en=1, m_we=1, no lanes written; completes normally.
//  - m_* are 0 in cycles with no good grant.
//  - Perf counters wrap at 2**CNT_W.
//    - perf_stall increments when (i_req|d_req) && no grant. With the current rule this occurs
//      only during reset; reserved for future back-pressure.
//  - Reset mid-operation: response due the next cycle is dropped (rvalid stays 0).
//    Any write already presented on m_* that cycle has completed.
// TESTING
//  1. Reset 3 cycles with i_req=d_req=1 -> all outputs 0 throughout; first grant in cycle after reset falls.
//  2. mem[0]=32'h0000_0297, i_req i_addr=32'h8000_0000 -> cycle0: i_gnt=1, m_en=1, m_idx=0; cycle1: i_rvalid=1, i_rdata=32'h0000_0297.
//  3. i_req=d_req=1 held, D_STREAK_MAX=4 -> grant sequence D,D,D,D,I,D,D,D,D,I; perf_d_cnt=8, perf_i_cnt=2 after 10 cycles.
//  4. Store d_addr=32'h8000_0010, d_wdata=32'hDEAD_BEEF, d_wstrb=4'b0011 over mem[4]=0 -> m_idx=4, m_wstrb=4'b0011, d_rvalid next cycle with d_rdata=0; load same address -> 32'h0000_BEEF.
//  5. d_addr=32'h8000_2020 (idx 2056), then 32'h8000_0002, then 32'h7FFF_FFFC -> each: d_gnt=1, m_en=0, next cycle d_rvalid=1, d_err=1, d_rdata=0.
//  6. Fetch granted in cycle N, reset=1 in cycle N+1 -> i_rvalid=0 in N+1 and after; counters 0.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares the unified RV32I memory array between fetch (I) and load/store (D).
// D has fixed priority, but a starvation guard forces an I grant after D_STREAK_MAX consecutive
// D grants while I waits. Every request is grantable each cycle. The single outstanding response
// retires one cycle after its grant and is routed back to the port that owns it.
module riscv_mem_arbiter #(
  parameter logic [31:0] ENTRY        = 32'h8000_0000,
  parameter int unsigned MEMSIZE      = 2056,
  parameter int unsigned IDX_W        = 12,
  parameter int unsigned D_STREAK_MAX = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [31:0]      i_rdata,
  output logic             i_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [3:0]       d_wstrb,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             d_err,
  output logic             m_en,
  output logic             m_we,
  output logic [3:0]       m_wstrb,
  output logic [IDX_W-1:0] m_idx,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata,
  output logic [CNT_W-1:0] perf_i_cnt,
  output logic [CNT_W-1:0] perf_d_cnt,
  output logic [CNT_W-1:0] perf_stall
);

  localparam int unsigned STREAK_W = $clog2(D_STREAK_MAX + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  owner_e             owner_q, owner_d;
  logic               fault_q, fault_d;
  logic               store_q, store_d;
  logic [STREAK_W-1:0] streak_q;
  logic               streak_max;
  logic               grant_i, grant_d, grant_any;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_word;
  logic               addr_fault;
  logic               good;
  logic [CNT_W-1:0]   i_cnt_q, d_cnt_q, stall_q;

  assign streak_max = (streak_q == STREAK_W'(D_STREAK_MAX));
  assign grant_any  = grant_i | grant_d;

  // Arbitration: D first unless I has waited through a full D streak; nothing granted in reset.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset) begin
      if (d_req && !(i_req && streak_max)) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  // Byte address to word index translation plus range and alignment check for the winner.
  always_comb begin
    sel_addr   = grant_d ? d_addr : i_addr;
    sel_word   = (sel_addr - ENTRY) >> 2;
    addr_fault = (sel_addr < ENTRY) || (sel_word >= 32'(MEMSIZE)) || (sel_addr[1:0] != 2'b00);
    good       = grant_any && !addr_fault;
  end

  // Next response owner, loaded every cycle from this cycle's grant decision.
  always_comb begin
    owner_d = OWN_NONE;
    fault_d = 1'b0;
    store_d = 1'b0;
    if (grant_d) begin
      owner_d = OWN_D;
      fault_d = addr_fault;
      store_d = d_we;
    end else if (grant_i) begin
      owner_d = OWN_I;
      fault_d = addr_fault;
    end
  end

  // Response owner register; reset drops any response that was due.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      fault_q <= 1'b0;
      store_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      fault_q <= fault_d;
      store_q <= store_d;
    end
  end

  // Consecutive D grants while I is waiting, saturating at the guard limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else if (!i_req || grant_i) begin
      streak_q <= '0;
    end else if (grant_d && !streak_max) begin
      streak_q <= streak_q + STREAK_W'(1);
    end
  end

  // Performance counters, wrapping naturally at 2**CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
      stall_q <= '0;
    end else begin
      if (grant_i) i_cnt_q <= i_cnt_q + CNT_W'(1);
      if (grant_d) d_cnt_q <= d_cnt_q + CNT_W'(1);
      if ((i_req || d_req) && !grant_any) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign i_gnt   = grant_i;
  assign d_gnt   = grant_d;
  assign m_en    = good;
  assign m_we    = good && grant_d && d_we;
  assign m_wstrb = (good && grant_d) ? d_wstrb : 4'h0;
  assign m_idx   = good ? sel_word[IDX_W-1:0] : '0;
  assign m_wdata = (good && grant_d) ? d_wdata : 32'h0;

  assign i_rvalid = !reset && (owner_q == OWN_I);
  assign i_err    = i_rvalid && fault_q;
  assign i_rdata  = (i_rvalid && !fault_q) ? m_rdata : 32'h0;
  assign d_rvalid = !reset && (owner_q == OWN_D);
  assign d_err    = d_rvalid && fault_q;
  assign d_rdata  = (d_rvalid && !fault_q && !store_q) ? m_rdata : 32'h0;

  assign perf_i_cnt = reset ? '0 : i_cnt_q;
  assign perf_d_cnt = reset ? '0 : d_cnt_q;
  assign perf_stall = reset ? '0 : stall_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Testbench for riscv_mem_arbiter: directed reset/streak/fault sequences, a vector table,
// and a randomized phase checked against a transaction-level reference model.
module tb_riscv_mem_arbiter;

  localparam logic [31:0] ENTRY   = 32'h8000_0000;
  localparam int unsigned MEMSIZE = 2056;
  localparam int unsigned IDX_W   = 12;
  localparam int unsigned DMAX    = 4;
  localparam int unsigned CNT_W   = 32;

  logic             clk;
  logic             reset;
  logic             i_req, d_req, d_we;
  logic [31:0]      i_addr, d_addr, d_wdata;
  logic [3:0]       d_wstrb;
  logic             i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err;
  logic [31:0]      i_rdata, d_rdata;
  logic             m_en, m_we;
  logic [3:0]       m_wstrb;
  logic [IDX_W-1:0] m_idx;
  logic [31:0]      m_wdata, m_rdata;
  logic [CNT_W-1:0] perf_i_cnt, perf_d_cnt, perf_stall;

  int n_checks = 0;
  int n_errors = 0;

  riscv_mem_arbiter #(
    .ENTRY(ENTRY), .MEMSIZE(MEMSIZE), .IDX_W(IDX_W), .D_STREAK_MAX(DMAX), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_en(m_en), .m_we(m_we), .m_wstrb(m_wstrb), .m_idx(m_idx), .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .perf_i_cnt(perf_i_cnt), .perf_d_cnt(perf_d_cnt), .perf_stall(perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Deterministic initial memory contents, with a few fixed words used by the vector table.
  function automatic logic [31:0] fill(input int i);
    case (i)
      0:       return 32'h0000_0297;
      4:       return 32'h0000_0000;
      8:       return 32'h1234_5678;
      2055:    return 32'hCAFE_F00D;
      default: return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // Memory array driven by the DUT: samples m_* before the edge, read data valid next cycle.
  logic [31:0] mem [MEMSIZE];
  logic        cap_en, cap_we;
  logic [3:0]  cap_strb;
  int          cap_idx;
  logic [31:0] cap_wdata;
  initial begin
    for (int i = 0; i < int'(MEMSIZE); i++) mem[i] = fill(i);
    m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      cap_en = m_en; cap_we = m_we; cap_strb = m_wstrb; cap_idx = int'(m_idx); cap_wdata = m_wdata;
      @(posedge clk);
      if (cap_en && cap_idx < int'(MEMSIZE)) begin
        m_rdata <= mem[cap_idx];
        if (cap_we)
          for (int b = 0; b < 4; b++)
            if (cap_strb[b]) mem[cap_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
      end
    end
  end

  // Reference memory image kept by the model.
  logic [31:0] ref_mem [MEMSIZE];

  task automatic ref_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
  endtask

  // Fault rule from the address map: below ENTRY, past the array, or not word aligned.
  function automatic logic addr_bad(input logic [31:0] a);
    longint unsigned x;
    x = 64'(a);
    if (x < 64'(ENTRY)) return 1'b1;
    if ((x - 64'(ENTRY)) / 4 >= 64'(MEMSIZE)) return 1'b1;
    return (x % 4) != 0;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((64'(a) - 64'(ENTRY)) / 4);
  endfunction

  function automatic logic [31:0] gen_addr();
    int unsigned r;
    r = $urandom % 16;
    case (r)
      0:          return ENTRY - 32'(4 * (1 + $urandom % 8));
      1:          return ENTRY + 32'(4 * (MEMSIZE + $urandom % 8));
      2:          return 32'hFFFF_FFFC;
      3:          return ENTRY + 32'(4 * ($urandom % 24)) + 32'(1 + $urandom % 3);
      4, 5, 6, 7, 8, 9: return ENTRY + 32'(4 * ($urandom % 24));
      default:    return ENTRY + 32'(4 * ($urandom % MEMSIZE));
    endcase
  endfunction

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dstrb;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        e_ig;
    logic        e_dg;
    logic        e_men;
    logic [11:0] e_idx;
    logic        e_we;
    logic [3:0]  e_strb;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl [12];

  logic        any_out;
  logic        exp_i, exp_d, flt, good, hold_i, hold_d;
  logic        pend_i, pend_d, pend_err;
  logic [31:0] pend_rdata, a;
  int          widx, streak;
  logic [31:0] cnt_i, cnt_d;

  initial begin
    for (int i = 0; i < int'(MEMSIZE); i++) ref_mem[i] = fill(i);

    //                ireq  iaddr          dreq  dwe   dstrb daddr          dwdata         ig    dg    men   idx       we    strb  err   rdata
    tbl[0]  = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b1, 12'd0,    1'b0, 4'h0, 1'b0, 32'h0000_0297};
    tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 4'h3, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 12'd4,    1'b1, 4'h3, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 32'h8000_0010, 32'h0,         1'b0, 1'b1, 1'b1, 12'd4,    1'b0, 4'h0, 1'b0, 32'h0000_BEEF};
    tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 32'h8000_2020, 32'h0,         1'b0, 1'b1, 1'b0, 12'd0,    1'b0, 4'h0, 1'b1, 32'h0};
    tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 32'h8000_0002, 32'h0,         1'b0, 1'b1, 1'b0, 12'd0,    1'b0, 4'h0, 1'b1, 32'h0};
    tbl[5]  = '{1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 32'h7FFF_FFFC, 32'h0,         1'b0, 1'b1, 1'b0, 12'd0,    1'b0, 4'h0, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 32'h8000_0001, 1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 12'd0,    1'b0, 4'h0, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 32'h0,         1'b1, 1'b1, 4'h0, 32'h8000_0020, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 12'd8,    1'b1, 4'h0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 32'h8000_0020, 32'h0,         1'b0, 1'b1, 1'b1, 12'd8,    1'b0, 4'h0, 1'b0, 32'h1234_5678};
    tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 32'h8000_201C, 32'h0,         1'b0, 1'b1, 1'b1, 12'd2055, 1'b0, 4'h0, 1'b0, 32'hCAFE_F00D};
    tbl[10] = '{1'b1, 32'h8000_0004, 1'b1, 1'b0, 4'h0, 32'h8000_0000, 32'h0,         1'b0, 1'b1, 1'b1, 12'd0,    1'b0, 4'h0, 1'b0, 32'h0000_0297};
    tbl[11] = '{1'b1, 32'h8000_201C, 1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b1, 12'd2055, 1'b0, 4'h0, 1'b0, 32'hCAFE_F00D};

    // Reset held three cycles with both ports requesting: every output must stay 0.
    reset = 1'b1;
    idle();
    i_req = 1'b1; i_addr = 32'h8000_0000;
    d_req = 1'b1; d_addr = 32'h8000_0004;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      any_out = i_gnt | d_gnt | i_rvalid | d_rvalid | i_err | d_err | m_en | m_we | (|m_wstrb) |
                (|m_idx) | (|m_wdata) | (|i_rdata) | (|d_rdata) | (|perf_i_cnt) | (|perf_d_cnt) |
                (|perf_stall);
      chk($sformatf("reset_outputs_c%0d", k), 32'(any_out), 32'h0);
      tick();
    end
    reset = 1'b0;

    // Both ports held after reset: D,D,D,D,I repeating.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("streak_dgnt_c%0d", k), 32'(d_gnt), 32'((k % 5) != 4));
      chk($sformatf("streak_ignt_c%0d", k), 32'(i_gnt), 32'((k % 5) == 4));
      tick();
    end
    idle();
    @(negedge clk);
    chk("streak_perf_d", perf_d_cnt, 32'd8);
    chk("streak_perf_i", perf_i_cnt, 32'd2);
    chk("streak_perf_stall", perf_stall, 32'd0);
    chk("streak_last_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("streak_last_i_rdata", i_rdata, 32'h0000_0297);
    tick();

    // Vector table: one grant cycle, then an idle cycle carrying the response.
    for (int r = 0; r < 12; r++) begin
      i_req = tbl[r].ireq; i_addr = tbl[r].iaddr;
      d_req = tbl[r].dreq; d_we = tbl[r].dwe; d_wstrb = tbl[r].dstrb;
      d_addr = tbl[r].daddr; d_wdata = tbl[r].dwdata;
      @(negedge clk);
      chk($sformatf("row%0d_i_gnt", r), 32'(i_gnt), 32'(tbl[r].e_ig));
      chk($sformatf("row%0d_d_gnt", r), 32'(d_gnt), 32'(tbl[r].e_dg));
      chk($sformatf("row%0d_m_en", r), 32'(m_en), 32'(tbl[r].e_men));
      chk($sformatf("row%0d_m_idx", r), 32'(m_idx), 32'(tbl[r].e_idx));
      chk($sformatf("row%0d_m_we", r), 32'(m_we), 32'(tbl[r].e_we));
      chk($sformatf("row%0d_m_wstrb", r), 32'(m_wstrb), 32'(tbl[r].e_strb));
      if (tbl[r].e_we) begin
        chk($sformatf("row%0d_m_wdata", r), m_wdata, tbl[r].dwdata);
        ref_write(int'(tbl[r].e_idx), tbl[r].dwdata, tbl[r].dstrb);
      end
      tick();
      idle();
      @(negedge clk);
      chk($sformatf("row%0d_i_rvalid", r), 32'(i_rvalid), 32'(tbl[r].e_ig));
      chk($sformatf("row%0d_d_rvalid", r), 32'(d_rvalid), 32'(tbl[r].e_dg));
      if (tbl[r].e_ig) begin
        chk($sformatf("row%0d_i_err", r), 32'(i_err), 32'(tbl[r].e_err));
        chk($sformatf("row%0d_i_rdata", r), i_rdata, tbl[r].e_rdata);
      end else begin
        chk($sformatf("row%0d_d_err", r), 32'(d_err), 32'(tbl[r].e_err));
        chk($sformatf("row%0d_d_rdata", r), d_rdata, tbl[r].e_rdata);
      end
      tick();
    end

    // Fetch granted, then reset the very next cycle: its response must be dropped.
    i_req = 1'b1; i_addr = 32'h8000_0000;
    @(negedge clk);
    chk("rstmid_i_gnt", 32'(i_gnt), 32'd1);
    tick();
    idle();
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_i_rvalid_n1", 32'(i_rvalid), 32'd0);
    chk("rstmid_perf_i_n1", perf_i_cnt, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_i_rvalid_n2", 32'(i_rvalid), 32'd0);
    chk("rstmid_perf_i_n2", perf_i_cnt, 32'd0);
    chk("rstmid_perf_d_n2", perf_d_cnt, 32'd0);
    tick();

    // Randomized traffic against the transaction-level model.
    streak = 0; cnt_i = 32'd0; cnt_d = 32'd0;
    pend_i = 1'b0; pend_d = 1'b0; pend_err = 1'b0; pend_rdata = 32'h0;
    hold_i = 1'b0; hold_d = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold_i) begin
        i_req = ($urandom % 4) != 0;
        i_addr = gen_addr();
      end
      if (!hold_d) begin
        d_req = ($urandom % 5) < 3;
        d_we = 1'($urandom % 2);
        d_wstrb = 4'($urandom);
        d_addr = gen_addr();
        d_wdata = $urandom;
      end
      exp_d = d_req && !(i_req && streak == int'(DMAX));
      exp_i = !exp_d && i_req;
      a = exp_d ? d_addr : i_addr;
      flt = (exp_i || exp_d) && addr_bad(a);
      good = (exp_i || exp_d) && !flt;
      widx = good ? word_of(a) : 0;
      @(negedge clk);
      chk("rnd_i_gnt", 32'(i_gnt), 32'(exp_i));
      chk("rnd_d_gnt", 32'(d_gnt), 32'(exp_d));
      chk("rnd_m_en", 32'(m_en), 32'(good));
      if (good) chk("rnd_m_idx", 32'(m_idx), 32'(widx));
      chk("rnd_m_we", 32'(m_we), 32'(good && exp_d && d_we));
      chk("rnd_m_wstrb", 32'(m_wstrb), (good && exp_d) ? 32'(d_wstrb) : 32'h0);
      if (good && exp_d && d_we) chk("rnd_m_wdata", m_wdata, d_wdata);
      chk("rnd_i_rvalid", 32'(i_rvalid), 32'(pend_i));
      chk("rnd_d_rvalid", 32'(d_rvalid), 32'(pend_d));
      if (pend_i) begin
        chk("rnd_i_err", 32'(i_err), 32'(pend_err));
        chk("rnd_i_rdata", i_rdata, pend_rdata);
      end
      if (pend_d) begin
        chk("rnd_d_err", 32'(d_err), 32'(pend_err));
        chk("rnd_d_rdata", d_rdata, pend_rdata);
      end
      chk("rnd_perf_i", perf_i_cnt, cnt_i);
      chk("rnd_perf_d", perf_d_cnt, cnt_d);
      chk("rnd_perf_stall", perf_stall, 32'd0);

      pend_i = exp_i;
      pend_d = exp_d;
      pend_err = flt;
      pend_rdata = (good && !(exp_d && d_we)) ? ref_mem[widx] : 32'h0;
      if (good && exp_d && d_we) ref_write(widx, d_wdata, d_wstrb);
      if (!i_req || exp_i) streak = 0;
      else if (exp_d && streak < int'(DMAX)) streak++;
      if (exp_i) cnt_i = cnt_i + 32'd1;
      if (exp_d) cnt_d = cnt_d + 32'd1;
      hold_i = i_req && !exp_i;
      hold_d = d_req && !exp_d;
      tick();
    end
    idle();
    @(negedge clk);
    chk("final_perf_i", perf_i_cnt, cnt_i);
    chk("final_perf_d", perf_d_cnt, cnt_d);
    chk("final_i_rvalid", 32'(i_rvalid), 32'(pend_i));
    chk("final_d_rvalid", 32'(d_rvalid), 32'(pend_d));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
